move_sequencer: RTL and testbench
=================================

Name: move_sequencer

Overview:
Initiator side of the card-move handshake: owns the authoritative board state, accepts player move commands, and drives one request per command into the move engine. It holds ready, source, source_offset, destination and the pile inputs, then waits for move_ready. It then commits the returned piles and the successful flag into its board registers. It sits between the player/input decoder and the move engine, and feeds the display/scoring logic.

Parameters:
TIMEOUT_CYCLES, 64, max clocks to wait for move_ready before aborting a request
CARD_W, 7, bits per card slot: [0] face-up, [2:1] suit (00 H, 01 C, 10 D, 11 S), [6:3] rank 1..13, all-zero = empty

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
load_valid  in  1  one-cycle pulse: latch a fresh deal from load_* buses
load_stock  in  168  dealt stock pile
load_tableau  in  7*133  dealt tableaus 1..7, tableau1 in LSBs
cmd_valid  in  1  player command valid
cmd_ready  out  1  sequencer can accept a command
cmd_source  in  4  0 talon, 1..7 tableau, 8 draw
cmd_offset  in  4  source_offset passed through
cmd_destination  in  4  0 foundation, 1..7 tableau
ready  out  1  request to move engine
source, source_offset, destination  out  4 each  registered copies of the command
stock_pile_input, talon_pile_input  out  168 each  current board to engine
tableau1_input..tableau7_input  out  133 each  current board to engine
move_ready  in  1  engine acknowledge
successful  in  1  engine move result
stock_pile, talon_pile, tableau1..tableau7  in  as above  engine result piles
foundation_cards  in  28  engine foundation state
result_valid  out  1  one-cycle pulse per finished command
result_ok  out  1  valid with result_valid
board_stock, board_talon  out  168 each  committed board
board_tableau  out  7*133  committed board
board_foundation  out  28  committed foundation
move_count  out  16  count of successful moves, saturating at 0xFFFF
game_won  out  1  all four foundation ranks == 13

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs and board registers 0; cmd_ready 0 while rst is high, 1 in the first IDLE cycle after release.
- States: IDLE, LOAD, EXEC, SETTLE, COMMIT.
- IDLE: cmd_ready=1.
  - load_valid has priority over cmd_valid in the same cycle. It latches load_* into the board, clears talon, foundation and move_count, and drops the command.
  - Command accepted on cmd_valid&cmd_ready: register source, offset and destination; go to LOAD.
  - Illegal command (source>8, or destination>7 with source≠8): no engine traffic; next cycle result_valid=1, result_ok=0; stay IDLE.
- LOAD: ready=1, cmd_ready=0, *_input driven from board registers. Wait for move_ready=1, then go to EXEC. If the wait counter reaches TIMEOUT_CYCLES, drop ready, pulse result_valid with result_ok=0, and return to IDLE with the board unchanged.
- EXEC: ready=1 for exactly one clock (engine execute phase), then SETTLE.
- SETTLE: ready=0 for one clock so the engine cannot re-execute; engine outputs settle.
- COMMIT:
  - If successful=1: copy all engine piles and foundation_cards into the board, increment move_count, pulse result_valid with result_ok=1.
  - Else: board unchanged, pulse result_valid with result_ok=0.
  - Return to IDLE.
- Per accepted command: ready is high for at least 2 clocks; minimum latency from accept to result_valid is 4 clocks.
- game_won is combinational from board_foundation rank fields [6:3],[13:10],[20:17],[27:24], all ==13.
- rst mid-transaction: immediate return to IDLE, ready=0, no result_valid pulse.
- load_valid outside IDLE is ignored.

Optional Feature:
MOVE_SEQ_UNDO_EN
- Enabled:
  - Adds input cmd_undo (1).
  - Each COMMIT with successful=1 first snapshots the prior board and move_count into a one-deep shadow, and sets undo_avail.
  - cmd_undo in IDLE with undo_avail=1 restores the shadow, clears undo_avail, and pulses result_valid/result_ok=1.
  - cmd_undo with undo_avail=0 pulses result_ok=0.
  - load_valid clears undo_avail.
  - cmd_undo has priority over cmd_valid, but not over load_valid.
- Disabled: no port, no shadow registers.

Decomposition:
- Package solitaire_pkg: suit constants HEARTS/CLUBS/DIAMONDS/SPADES, CARD_W, TABLEAU_SLOTS=19, STOCK_SLOTS=24, source/destination code constants (SRC_TALON=0, SRC_DRAW=8, DST_FOUNDATION=0), FSM state enum.
- One sub-module: move_seq_timeout, a loadable down-counter with an expire flag used in LOAD.

Test Plan:
- Reset then load_valid with tableau1 top=K♠ face-up → board_tableau matches load, move_count=0, cmd_ready=1, game_won=0.
- Tableau2 top Q♥ face-up, tableau1 top K♠; cmd src=2 dst=1 offset=0 with model engine returning successful=1 → ready high ≥2 clocks, result_ok=1 at accept+4, move_count=1, board updated.
- Same command with model returning successful=0 → result_ok=0, board and move_count unchanged.
- Engine never asserts move_ready → result_valid with result_ok=0 exactly TIMEOUT_CYCLES (64) clocks after LOAD entry, ready=0, back to IDLE.
- cmd_source=9 → result_ok=0 next cycle, ready never asserted; cmd_source=8 with cmd_destination=15 → accepted.
- With MOVE_SEQ_UNDO_EN: successful move then cmd_undo → board and move_count restored; a second cmd_undo → result_ok=0.

Source files
------------

// File: rtl/solitaire_pkg.sv
// Shared solitaire encodings: card slot layout, pile widths, source and
// destination codes, and the move sequencer state type.
package solitaire_pkg;

  // Card slot: [0] face-up, [2:1] suit, [6:3] rank 1..13; all-zero is empty
  localparam int CARD_W        = 7;
  localparam int TABLEAU_SLOTS = 19;
  localparam int STOCK_SLOTS   = 24;
  localparam int NUM_TABLEAU   = 7;
  localparam int NUM_FOUND     = 4;

  localparam int STOCK_W     = CARD_W * STOCK_SLOTS;     // 168
  localparam int TABLEAU_W   = CARD_W * TABLEAU_SLOTS;   // 133
  localparam int BOARD_TAB_W = NUM_TABLEAU * TABLEAU_W;  // 931
  localparam int FOUND_W     = NUM_FOUND * CARD_W;       // 28

  localparam logic [1:0] HEARTS   = 2'b00;
  localparam logic [1:0] CLUBS    = 2'b01;
  localparam logic [1:0] DIAMONDS = 2'b10;
  localparam logic [1:0] SPADES   = 2'b11;

  localparam logic [3:0] RANK_KING = 4'd13;

  localparam logic [3:0] SRC_TALON      = 4'd0;
  localparam logic [3:0] SRC_DRAW       = 4'd8;
  localparam logic [3:0] DST_FOUNDATION = 4'd0;
  localparam logic [3:0] DST_MAX        = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_EXEC   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_COMMIT = 3'd4
  } seq_state_t;

  // A draw ignores the destination field, so only non-draw sources need a legal destination
  function automatic logic cmd_illegal(input logic [3:0] src, input logic [3:0] dst);
    return (src > SRC_DRAW) || ((dst > DST_MAX) && (src != SRC_DRAW));
  endfunction

endpackage

// File: rtl/move_seq_timeout.sv
// Loadable down-counter bounding how long the sequencer waits for the engine.
// expired is high once TIMEOUT_CYCLES counting cycles have elapsed since load.
module move_seq_timeout #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Reload while idle, count down while waiting, park at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RELOAD;
    end else if (load) begin
      count <= RELOAD;
    end else if (en && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/move_sequencer.sv
// Initiator of the card-move handshake. Owns the committed board, issues one
// engine request per legal command, and commits the engine result on success.
// Handshake: a command transfers on a clock where cmd_valid && cmd_ready; the
// engine request (ready) stays high until move_ready is sampled, then for one
// more execute clock. Optional one-deep undo is built when MOVE_SEQ_UNDO_EN
// is defined.
module move_sequencer
  import solitaire_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_valid,
  input  logic [STOCK_W-1:0]     load_stock,
  input  logic [BOARD_TAB_W-1:0] load_tableau,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_source,
  input  logic [3:0]             cmd_offset,
  input  logic [3:0]             cmd_destination,
`ifdef MOVE_SEQ_UNDO_EN
  input  logic                   cmd_undo,
`endif
  output logic                   ready,
  output logic [3:0]             source,
  output logic [3:0]             source_offset,
  output logic [3:0]             destination,
  output logic [STOCK_W-1:0]     stock_pile_input,
  output logic [STOCK_W-1:0]     talon_pile_input,
  output logic [TABLEAU_W-1:0]   tableau1_input,
  output logic [TABLEAU_W-1:0]   tableau2_input,
  output logic [TABLEAU_W-1:0]   tableau3_input,
  output logic [TABLEAU_W-1:0]   tableau4_input,
  output logic [TABLEAU_W-1:0]   tableau5_input,
  output logic [TABLEAU_W-1:0]   tableau6_input,
  output logic [TABLEAU_W-1:0]   tableau7_input,
  input  logic                   move_ready,
  input  logic                   successful,
  input  logic [STOCK_W-1:0]     stock_pile,
  input  logic [STOCK_W-1:0]     talon_pile,
  input  logic [TABLEAU_W-1:0]   tableau1,
  input  logic [TABLEAU_W-1:0]   tableau2,
  input  logic [TABLEAU_W-1:0]   tableau3,
  input  logic [TABLEAU_W-1:0]   tableau4,
  input  logic [TABLEAU_W-1:0]   tableau5,
  input  logic [TABLEAU_W-1:0]   tableau6,
  input  logic [TABLEAU_W-1:0]   tableau7,
  input  logic [FOUND_W-1:0]     foundation_cards,
  output logic                   result_valid,
  output logic                   result_ok,
  output logic [STOCK_W-1:0]     board_stock,
  output logic [STOCK_W-1:0]     board_talon,
  output logic [BOARD_TAB_W-1:0] board_tableau,
  output logic [FOUND_W-1:0]     board_foundation,
  output logic [15:0]            move_count,
  output logic                   game_won,
  output logic [2:0]             state_dbg
);

  seq_state_t state;
  logic       tmo_expired;
  logic [BOARD_TAB_W-1:0] engine_tableau;

`ifdef MOVE_SEQ_UNDO_EN
  logic                   undo_avail;
  logic [STOCK_W-1:0]     shadow_stock;
  logic [STOCK_W-1:0]     shadow_talon;
  logic [BOARD_TAB_W-1:0] shadow_tableau;
  logic [FOUND_W-1:0]     shadow_found;
  logic [15:0]            shadow_count;
`endif

  move_seq_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    (state == ST_IDLE),
    .en      (state == ST_LOAD),
    .expired (tmo_expired)
  );

  assign engine_tableau = {tableau7, tableau6, tableau5, tableau4,
                           tableau3, tableau2, tableau1};

  // The engine always sees the committed board; it only matters while ready is high
  assign stock_pile_input = board_stock;
  assign talon_pile_input = board_talon;
  assign tableau1_input   = board_tableau[0*TABLEAU_W +: TABLEAU_W];
  assign tableau2_input   = board_tableau[1*TABLEAU_W +: TABLEAU_W];
  assign tableau3_input   = board_tableau[2*TABLEAU_W +: TABLEAU_W];
  assign tableau4_input   = board_tableau[3*TABLEAU_W +: TABLEAU_W];
  assign tableau5_input   = board_tableau[4*TABLEAU_W +: TABLEAU_W];
  assign tableau6_input   = board_tableau[5*TABLEAU_W +: TABLEAU_W];
  assign tableau7_input   = board_tableau[6*TABLEAU_W +: TABLEAU_W];

  // Won when every foundation holds a king on top
  assign game_won = (board_foundation[6:3]   == RANK_KING) &&
                    (board_foundation[13:10] == RANK_KING) &&
                    (board_foundation[20:17] == RANK_KING) &&
                    (board_foundation[27:24] == RANK_KING);

  assign state_dbg = state;

  // Sequencer FSM with registered handshake, result and board state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      cmd_ready        <= 1'b0;
      ready            <= 1'b0;
      source           <= '0;
      source_offset    <= '0;
      destination      <= '0;
      result_valid     <= 1'b0;
      result_ok        <= 1'b0;
      board_stock      <= '0;
      board_talon      <= '0;
      board_tableau    <= '0;
      board_foundation <= '0;
      move_count       <= '0;
`ifdef MOVE_SEQ_UNDO_EN
      undo_avail       <= 1'b0;
      shadow_stock     <= '0;
      shadow_talon     <= '0;
      shadow_tableau   <= '0;
      shadow_found     <= '0;
      shadow_count     <= '0;
`endif
    end else begin
      result_valid <= 1'b0;
      result_ok    <= 1'b0;
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (load_valid) begin
            board_stock      <= load_stock;
            board_tableau    <= load_tableau;
            board_talon      <= '0;
            board_foundation <= '0;
            move_count       <= '0;
`ifdef MOVE_SEQ_UNDO_EN
            undo_avail       <= 1'b0;
          end else if (cmd_undo) begin
            result_valid <= 1'b1;
            if (undo_avail) begin
              board_stock      <= shadow_stock;
              board_talon      <= shadow_talon;
              board_tableau    <= shadow_tableau;
              board_foundation <= shadow_found;
              move_count       <= shadow_count;
              undo_avail       <= 1'b0;
              result_ok        <= 1'b1;
            end
`endif
          end else if (cmd_valid && cmd_ready) begin
            if (cmd_illegal(cmd_source, cmd_destination)) begin
              result_valid <= 1'b1;
            end else begin
              source        <= cmd_source;
              source_offset <= cmd_offset;
              destination   <= cmd_destination;
              ready         <= 1'b1;
              cmd_ready     <= 1'b0;
              state         <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (move_ready) begin
            state <= ST_EXEC;
          end else if (tmo_expired) begin
            ready        <= 1'b0;
            result_valid <= 1'b1;
            cmd_ready    <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          ready <= 1'b0;
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          result_valid <= 1'b1;
          if (successful) begin
`ifdef MOVE_SEQ_UNDO_EN
            shadow_stock   <= board_stock;
            shadow_talon   <= board_talon;
            shadow_tableau <= board_tableau;
            shadow_found   <= board_foundation;
            shadow_count   <= move_count;
            undo_avail     <= 1'b1;
`endif
            board_stock      <= stock_pile;
            board_talon      <= talon_pile;
            board_tableau    <= engine_tableau;
            board_foundation <= foundation_cards;
            if (move_count != 16'hFFFF) begin
              move_count <= move_count + 16'd1;
            end
            result_ok <= 1'b1;
          end
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          ready     <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed-plus-random bench for move_sequencer. The bench plays the move
// engine and keeps a pile-level model of the committed board.
`define CHK(T, O, E) \
  begin \
    vec_cnt++; \
    assert ((O) === (E)) else begin \
      err_cnt++; \
      $error("FAIL %s: observed %0h, expected %0h", T, O, E); \
    end \
  end

module tb_move_sequencer;
  import solitaire_pkg::*;

  localparam int TIMEOUT = 64;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                   load_valid = 1'b0;
  logic [STOCK_W-1:0]     load_stock = '0;
  logic [BOARD_TAB_W-1:0] load_tableau = '0;
  logic                   cmd_valid = 1'b0;
  logic                   cmd_ready;
  logic [3:0]             cmd_source = '0;
  logic [3:0]             cmd_offset = '0;
  logic [3:0]             cmd_destination = '0;
  logic                   cmd_undo = 1'b0;
  logic                   ready;
  logic [3:0]             source, source_offset, destination;
  logic [STOCK_W-1:0]     stock_pile_input, talon_pile_input;
  logic [TABLEAU_W-1:0]   tableau1_input, tableau2_input, tableau3_input, tableau4_input;
  logic [TABLEAU_W-1:0]   tableau5_input, tableau6_input, tableau7_input;
  logic                   move_ready = 1'b0;
  logic                   successful = 1'b0;
  logic [STOCK_W-1:0]     eng_stock = '0;
  logic [STOCK_W-1:0]     eng_talon = '0;
  logic [TABLEAU_W-1:0]   eng_tab [NUM_TABLEAU];
  logic [FOUND_W-1:0]     eng_found = '0;
  logic                   result_valid, result_ok;
  logic [STOCK_W-1:0]     board_stock, board_talon;
  logic [BOARD_TAB_W-1:0] board_tableau;
  logic [FOUND_W-1:0]     board_foundation;
  logic [15:0]            move_count;
  logic                   game_won;
  logic [2:0]             state_dbg;

  move_sequencer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_stock(load_stock), .load_tableau(load_tableau),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_source(cmd_source),
    .cmd_offset(cmd_offset), .cmd_destination(cmd_destination),
`ifdef MOVE_SEQ_UNDO_EN
    .cmd_undo(cmd_undo),
`endif
    .ready(ready), .source(source), .source_offset(source_offset), .destination(destination),
    .stock_pile_input(stock_pile_input), .talon_pile_input(talon_pile_input),
    .tableau1_input(tableau1_input), .tableau2_input(tableau2_input),
    .tableau3_input(tableau3_input), .tableau4_input(tableau4_input),
    .tableau5_input(tableau5_input), .tableau6_input(tableau6_input),
    .tableau7_input(tableau7_input),
    .move_ready(move_ready), .successful(successful),
    .stock_pile(eng_stock), .talon_pile(eng_talon),
    .tableau1(eng_tab[0]), .tableau2(eng_tab[1]), .tableau3(eng_tab[2]),
    .tableau4(eng_tab[3]), .tableau5(eng_tab[4]), .tableau6(eng_tab[5]),
    .tableau7(eng_tab[6]), .foundation_cards(eng_found),
    .result_valid(result_valid), .result_ok(result_ok),
    .board_stock(board_stock), .board_talon(board_talon),
    .board_tableau(board_tableau), .board_foundation(board_foundation),
    .move_count(move_count), .game_won(game_won), .state_dbg(state_dbg)
  );

  // scoreboard state
  int vec_cnt = 0;
  int err_cnt = 0;
  logic [0:0] exp_q[$];
  logic [0:0] sb_exp;

  // board model
  logic [STOCK_W-1:0]   exp_stock = '0, exp_talon = '0;
  logic [TABLEAU_W-1:0] exp_tab [NUM_TABLEAU];
  logic [FOUND_W-1:0]   exp_found = '0;
  logic [15:0]          exp_count = '0;
  logic                 m_undo_avail = 1'b0;
  logic [STOCK_W-1:0]   snap_stock = '0, snap_talon = '0;
  logic [TABLEAU_W-1:0] snap_tab [NUM_TABLEAU];
  logic [FOUND_W-1:0]   snap_found = '0;
  logic [15:0]          snap_count = '0;

  // scoreboard: every result pulse is matched against the expected queue
  always @(posedge clk) begin
    if (!rst && (result_valid === 1'b1)) begin
      vec_cnt++;
      if (exp_q.size() == 0) begin
        err_cnt++;
        $error("FAIL scoreboard: unexpected result_valid");
      end else begin
        sb_exp = exp_q.pop_front();
        if (result_ok !== sb_exp) begin
          err_cnt++;
          $error("FAIL scoreboard result_ok: observed %0b, expected %0b", result_ok, sb_exp);
        end
      end
      vec_cnt++;
      if (ready !== 1'b0) begin
        err_cnt++;
        $error("FAIL scoreboard: ready high while result reported");
      end
    end
  end

  function automatic logic [CARD_W-1:0] card(input int rank, input int suit, input int up);
    return CARD_W'(rank * 8 + suit * 2 + up);
  endfunction

  function automatic logic [STOCK_W-1:0] rand_pile(input int slots);
    logic [STOCK_W-1:0] p;
    p = '0;
    for (int s = 0; s < slots; s++)
      if ($urandom_range(0, 3) != 0)
        p[s*CARD_W +: CARD_W] = card($urandom_range(1, 13), $urandom_range(0, 3), $urandom_range(0, 1));
    return p;
  endfunction

  function automatic logic exp_won();
    int kings;
    kings = 0;
    for (int f = 0; f < NUM_FOUND; f++)
      if (((exp_found >> (f * CARD_W + 3)) & 28'hF) == 28'd13) kings++;
    return kings == NUM_FOUND;
  endfunction

  function automatic logic cmd_is_legal(input logic [3:0] src, input logic [3:0] dst);
    if (src > 4'd8) return 1'b0;
    if (src == 4'd8) return 1'b1;
    return dst <= 4'd7;
  endfunction

  task automatic clear_model();
    exp_stock = '0; exp_talon = '0; exp_found = '0; exp_count = '0; m_undo_avail = 1'b0;
    for (int i = 0; i < NUM_TABLEAU; i++) exp_tab[i] = '0;
  endtask

  task automatic rand_engine();
    logic [STOCK_W-1:0] tmp;
    eng_stock = rand_pile(STOCK_SLOTS);
    eng_talon = rand_pile(STOCK_SLOTS);
    for (int i = 0; i < NUM_TABLEAU; i++) begin
      tmp = rand_pile(TABLEAU_SLOTS);
      eng_tab[i] = tmp[TABLEAU_W-1:0];
    end
    tmp = rand_pile(NUM_FOUND);
    eng_found = tmp[FOUND_W-1:0];
  endtask

  task automatic check_board();
    `CHK("board_stock", board_stock, exp_stock)
    `CHK("board_talon", board_talon, exp_talon)
    for (int i = 0; i < NUM_TABLEAU; i++)
      `CHK($sformatf("board_tableau%0d", i + 1), board_tableau[i*TABLEAU_W +: TABLEAU_W], exp_tab[i])
    `CHK("board_foundation", board_foundation, exp_found)
    `CHK("move_count", move_count, exp_count)
    `CHK("game_won", game_won, exp_won())
  endtask

  // deal with K-spades face-up on tableau1 and Q-hearts face-up on tableau2
  task automatic make_deal(output logic [STOCK_W-1:0] st, output logic [BOARD_TAB_W-1:0] tb);
    logic [STOCK_W-1:0] tmp;
    st = rand_pile(STOCK_SLOTS);
    for (int i = 0; i < NUM_TABLEAU; i++) begin
      tmp = rand_pile(TABLEAU_SLOTS);
      tb[i*TABLEAU_W +: TABLEAU_W] = tmp[TABLEAU_W-1:0];
    end
    tb[0 +: CARD_W]         = card(13, 3, 1);
    tb[TABLEAU_W +: CARD_W] = card(12, 0, 1);
  endtask

  // driver: one-cycle deal pulse
  task automatic do_load(input logic [STOCK_W-1:0] st, input logic [BOARD_TAB_W-1:0] tb);
    @(negedge clk);
    load_valid = 1'b1; load_stock = st; load_tableau = tb;
    @(negedge clk);
    load_valid = 1'b0;
    exp_stock = st; exp_talon = '0; exp_found = '0; exp_count = '0; m_undo_avail = 1'b0;
    for (int i = 0; i < NUM_TABLEAU; i++) exp_tab[i] = tb[i*TABLEAU_W +: TABLEAU_W];
    check_board();
    `CHK("load_cmd_ready", cmd_ready, 1'b1)
    `CHK("load_result_valid", result_valid, 1'b0)
  endtask

  // driver: one command; the bench answers as the engine after mr_delay LOAD cycles (-1: never)
  task automatic do_cmd(input logic [3:0] src, input logic [3:0] off, input logic [3:0] dst,
                        input int mr_delay, input logic succ, input logic junk);
    logic legal, exp_ok, seen_ready;
    int k, ready_cnt, exp_lat, exp_rdy;
    legal  = cmd_is_legal(src, dst);
    exp_ok = legal && (mr_delay >= 0) && succ;
    exp_q.push_back(exp_ok);
    if (!legal) begin exp_lat = 0; exp_rdy = 0; end
    else if (mr_delay < 0) begin exp_lat = TIMEOUT; exp_rdy = TIMEOUT; end
    else begin exp_lat = mr_delay + 4; exp_rdy = mr_delay + 2; end
    successful = succ;
    @(negedge clk);
    `CHK("cmd_ready_idle", cmd_ready, 1'b1)
    cmd_valid = 1'b1; cmd_source = src; cmd_offset = off; cmd_destination = dst;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (legal) begin
      `CHK("source", source, src)
      `CHK("source_offset", source_offset, off)
      `CHK("destination", destination, dst)
    end
    k = 1; ready_cnt = 0; seen_ready = 1'b0;
    while ((k < 200) && (result_valid !== 1'b1)) begin
      if (ready === 1'b1) begin
        ready_cnt++;
        if (!seen_ready) begin
          seen_ready = 1'b1;
          `CHK("stock_pile_input", stock_pile_input, exp_stock)
          `CHK("talon_pile_input", talon_pile_input, exp_talon)
          `CHK("tableau1_input", tableau1_input, exp_tab[0])
          `CHK("tableau4_input", tableau4_input, exp_tab[3])
          `CHK("tableau7_input", tableau7_input, exp_tab[6])
        end
      end
      move_ready = (mr_delay >= 0) && (k - 1 >= mr_delay);
      load_valid = junk && (k == 2);
      if (load_valid) load_stock = rand_pile(STOCK_SLOTS);
      @(negedge clk);
      k++;
    end
    move_ready = 1'b0; load_valid = 1'b0;
    `CHK("result_valid", result_valid, 1'b1)
    `CHK("ready_at_result", ready, 1'b0)
    `CHK("latency", k - 1, exp_lat)
    `CHK("ready_cycles", ready_cnt, exp_rdy)
    `CHK("result_ok", result_ok, exp_ok)
    if (exp_ok) begin
      snap_stock = exp_stock; snap_talon = exp_talon; snap_found = exp_found; snap_count = exp_count;
      for (int i = 0; i < NUM_TABLEAU; i++) snap_tab[i] = exp_tab[i];
      m_undo_avail = 1'b1;
      exp_stock = eng_stock; exp_talon = eng_talon; exp_found = eng_found;
      for (int i = 0; i < NUM_TABLEAU; i++) exp_tab[i] = eng_tab[i];
      if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
    end
    check_board();
    `CHK("cmd_ready_after", cmd_ready, 1'b1)
  endtask

`ifdef MOVE_SEQ_UNDO_EN
  task automatic do_undo();
    exp_q.push_back(m_undo_avail);
    @(negedge clk);
    cmd_undo = 1'b1;
    @(negedge clk);
    cmd_undo = 1'b0;
    `CHK("undo_result_valid", result_valid, 1'b1)
    `CHK("undo_result_ok", result_ok, m_undo_avail)
    `CHK("undo_ready", ready, 1'b0)
    if (m_undo_avail) begin
      exp_stock = snap_stock; exp_talon = snap_talon; exp_found = snap_found; exp_count = snap_count;
      for (int i = 0; i < NUM_TABLEAU; i++) exp_tab[i] = snap_tab[i];
    end
    m_undo_avail = 1'b0;
    check_board();
  endtask
`endif

  // watchdog so the run always ends
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vec_cnt, err_cnt);
    $fatal(1, "watchdog");
  end

  logic [STOCK_W-1:0]     deal_stock;
  logic [BOARD_TAB_W-1:0] deal_tab;

  initial begin
    for (int i = 0; i < NUM_TABLEAU; i++) begin
      eng_tab[i] = '0; exp_tab[i] = '0; snap_tab[i] = '0;
    end
    // reset state
    repeat (2) @(negedge clk);
    `CHK("rst_cmd_ready", cmd_ready, 1'b0)
    `CHK("rst_ready", ready, 1'b0)
    `CHK("rst_result_valid", result_valid, 1'b0)
    check_board();
    rst = 1'b0;
    @(negedge clk);
    `CHK("first_idle_cmd_ready", cmd_ready, 1'b1)

    // fresh deal
    make_deal(deal_stock, deal_tab);
    do_load(deal_stock, deal_tab);

    // Q-hearts onto K-spades: success, then the same move refused
    rand_engine();
    do_cmd(4'd2, 4'd0, 4'd1, 0, 1'b1, 1'b0);
    rand_engine();
    do_cmd(4'd2, 4'd0, 4'd1, 0, 1'b0, 1'b0);

    // engine never answers
    rand_engine();
    do_cmd(4'd3, 4'd1, 4'd0, -1, 1'b1, 1'b0);

    // illegal and edge-legal codes
    do_cmd(4'd9, 4'd0, 4'd1, 0, 1'b1, 1'b0);
    do_cmd(4'd3, 4'd0, 4'd8, 0, 1'b1, 1'b0);
    rand_engine();
    do_cmd(4'd8, 4'd0, 4'd15, 2, 1'b1, 1'b0);

    // deal pulse during a transaction is ignored
    rand_engine();
    do_cmd(4'd0, 4'd0, 4'd0, 1, 1'b1, 1'b1);

    // foundation full of kings wins
    rand_engine();
    eng_found = {card(13, 3, 1), card(13, 2, 1), card(13, 1, 1), card(13, 0, 1)};
    do_cmd(4'd5, 4'd2, 4'd0, 3, 1'b1, 1'b0);

    // deal and command in the same cycle: deal wins, command dropped
    make_deal(deal_stock, deal_tab);
    @(negedge clk);
    load_valid = 1'b1; load_stock = deal_stock; load_tableau = deal_tab;
    cmd_valid = 1'b1; cmd_source = 4'd2; cmd_destination = 4'd1;
    @(negedge clk);
    load_valid = 1'b0; cmd_valid = 1'b0;
    exp_stock = deal_stock; exp_talon = '0; exp_found = '0; exp_count = '0; m_undo_avail = 1'b0;
    for (int i = 0; i < NUM_TABLEAU; i++) exp_tab[i] = deal_tab[i*TABLEAU_W +: TABLEAU_W];
    `CHK("dropped_cmd_ready", ready, 1'b0)
    `CHK("dropped_cmd_result", result_valid, 1'b0)
    check_board();
    @(negedge clk);
    `CHK("dropped_cmd_ready2", ready, 1'b0)

    // randomized commands
    for (int n = 0; n < 24; n++) begin
      rand_engine();
      do_cmd(4'($urandom_range(0, 10)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

`ifdef MOVE_SEQ_UNDO_EN
    rand_engine();
    do_cmd(4'd4, 4'd1, 4'd6, 0, 1'b1, 1'b0);
    do_undo();
    do_undo();
`endif

    // reset in the middle of a request
    rand_engine();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_source = 4'd3; cmd_offset = 4'd0; cmd_destination = 4'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    `CHK("mid_ready_before_rst", ready, 1'b1)
    #2 rst = 1'b1;
    #1;
    `CHK("mid_rst_ready", ready, 1'b0)
    `CHK("mid_rst_cmd_ready", cmd_ready, 1'b0)
    `CHK("mid_rst_result_valid", result_valid, 1'b0)
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    check_board();
    @(negedge clk);
    `CHK("post_rst_cmd_ready", cmd_ready, 1'b1)
    `CHK("post_rst_result_valid", result_valid, 1'b0)
    `CHK("post_rst_ready", ready, 1'b0)

    if (exp_q.size() != 0) begin
      err_cnt++;
      $error("FAIL scoreboard: %0d expected results never reported", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
